memory_access_stage: RTL and testbench

- MEM stage of the five-stage MIPS pipeline, directly downstream of the ALU stage.
- Consumes the ALU stage's registered inst2/result/to_mem2. Performs lw/sw through a req/ack data-memory port with a timeout. Produces registered writeback fields for the WB stage.
- Drives mem_busy back into the ALU stage's stall input so no instruction is lost during a multi-cycle access.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/wb_dest_decode.sv | 55 +++++
 rtl/memory_access_stage.sv | 149 ++++++++++++++
 tb/tb_memory_access_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct encodings and the MEM stage state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_J       = 6'b000010;

    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_MULTU_K = 6'b011001;
    localparam logic [5:0] FN_XOR     = 6'b100110;
    localparam logic [5:0] FN_SLL     = 6'b000000;

    typedef enum logic {
        IDLE,
        ACCESS
    } mem_state_t;

endpackage

// File: rtl/wb_dest_decode.sv
// Combinational destination decode: which register (if any) an instruction writes,
// and whether it is a load or a store. Also used by the hazard unit.
module wb_dest_decode
    import mips_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  wb_addr,
    output logic        writes_reg,
    output logic        is_load,
    output logic        is_store
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = inst[31:26];
    assign funct         = inst[5:0];
    assign unused_fields = ^{inst[25:21], inst[10:6]};

    always_comb begin
        wb_addr    = '0;
        writes_reg = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_MULTU_K ||
                    funct == FN_XOR || funct == FN_SLL) begin
                    wb_addr    = inst[15:11];
                    writes_reg = 1'b1;
                end
            end
            OP_ADDI, OP_LUI: begin
                wb_addr    = inst[20:16];
                writes_reg = 1'b1;
            end
            OP_LW: begin
                wb_addr    = inst[20:16];
                writes_reg = 1'b1;
                is_load    = 1'b1;
            end
            OP_SW: begin
                is_store = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_J: begin
                writes_reg = 1'b0;
            end
            default: begin
                writes_reg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: passes ALU results through, performs lw/sw over a req/ack port with a
// timeout, and stalls the ALU stage (mem_busy) while an access is outstanding.
module memory_access_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst2,
    input  logic [31:0] result,
    input  logic [31:0] to_mem2,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [31:0] inst3,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_addr,
    output logic        wb_enable,
    output logic        mem_busy,
    output logic        mem_fault
);

    mem_state_t  state, next_state;
    logic [7:0]  count, next_count;
    logic [31:0] held_inst, next_held_inst;

    logic        next_req, next_we, next_wb_enable, next_fault;
    logic [31:0] next_addr, next_wdata, next_inst3, next_wb_data;
    logic [4:0]  next_wb_addr;

    logic [31:0] dec_inst;
    logic [4:0]  dec_addr;
    logic        dec_writes, dec_load, dec_store, dec_write_ok;
    logic        timed_out;

    // While an access is pending the decoder looks at the latched memory instruction.
    assign dec_inst     = (state == ACCESS) ? held_inst : inst2;
    assign dec_write_ok = dec_writes && (dec_addr != 5'd0);
    assign mem_busy     = (state == ACCESS);
    assign timed_out    = ({1'b0, count} + 9'd1) >= 9'(TIMEOUT);

    wb_dest_decode u_decode (
        .inst       (dec_inst),
        .wb_addr    (dec_addr),
        .writes_reg (dec_writes),
        .is_load    (dec_load),
        .is_store   (dec_store)
    );

    always_comb begin
        next_state     = state;
        next_count     = count;
        next_held_inst = held_inst;
        next_req       = dmem_req;
        next_we        = dmem_we;
        next_addr      = dmem_addr;
        next_wdata     = dmem_wdata;
        next_inst3     = '0;
        next_wb_data   = wb_data;
        next_wb_addr   = '0;
        next_wb_enable = 1'b0;
        next_fault     = 1'b0;

        case (state)
            IDLE: begin
                if (dec_load || dec_store) begin
                    if (result[1:0] == 2'b00) begin
                        next_req       = 1'b1;
                        next_we        = dec_store;
                        next_addr      = result;
                        next_wdata     = to_mem2;
                        next_held_inst = inst2;
                        next_count     = '0;
                        next_state     = ACCESS;
                    end else begin
                        next_fault   = 1'b1;
                        next_inst3   = inst2;
                        next_wb_addr = dec_addr;
                    end
                end else begin
                    next_inst3     = inst2;
                    next_wb_addr   = dec_addr;
                    next_wb_enable = dec_write_ok;
                    if (dec_write_ok) begin
                        next_wb_data = result;
                    end
                end
            end
            ACCESS: begin
                // An ack on the timeout edge still completes the access normally.
                if (dmem_ack) begin
                    next_req     = 1'b0;
                    next_state   = IDLE;
                    next_inst3   = held_inst;
                    next_wb_addr = dec_addr;
                    if (dec_load && dec_write_ok) begin
                        next_wb_enable = 1'b1;
                        next_wb_data   = dmem_rdata;
                    end
                end else if (timed_out) begin
                    next_req   = 1'b0;
                    next_fault = 1'b1;
                    next_inst3 = held_inst;
                    next_state = IDLE;
                end else begin
                    next_count = count + 8'd1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            held_inst  <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            inst3      <= '0;
            wb_data    <= '0;
            wb_addr    <= '0;
            wb_enable  <= 1'b0;
            mem_fault  <= 1'b0;
        end else begin
            state      <= next_state;
            count      <= next_count;
            held_inst  <= next_held_inst;
            dmem_req   <= next_req;
            dmem_we    <= next_we;
            dmem_addr  <= next_addr;
            dmem_wdata <= next_wdata;
            inst3      <= next_inst3;
            wb_data    <= next_wb_data;
            wb_addr    <= next_wb_addr;
            wb_enable  <= next_wb_enable;
            mem_fault  <= next_fault;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a transaction model.
module tb_memory_access_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst2, result, to_mem2, dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, wb_enable, mem_busy, mem_fault;
    logic [31:0] dmem_addr, dmem_wdata, inst3, wb_data;
    logic [4:0]  wb_addr;

    int n_checks = 0;
    int n_fail   = 0;

    memory_access_stage #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst2      (inst2),
        .result     (result),
        .to_mem2    (to_mem2),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .inst3      (inst3),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr),
        .wb_enable  (wb_enable),
        .mem_busy   (mem_busy),
        .mem_fault  (mem_fault)
    );

    always #5 clk = ~clk;

    // Reference model state: what the stage must present after each edge.
    logic        exp_req, exp_we, exp_en, exp_fault, exp_busy;
    logic [31:0] exp_addr, exp_wdata, exp_inst3, exp_data;
    logic [4:0]  exp_waddr;
    logic [31:0] m_inst;
    int          m_waited;

    // Register written by an instruction, or -1 when it writes nothing.
    function automatic int destOf(input logic [31:0] i);
        case (i[31:26])
            6'h00:   return (i[5:0] == 6'h20 || i[5:0] == 6'h19 ||
                             i[5:0] == 6'h26 || i[5:0] == 6'h00) ? int'(i[15:11]) : -1;
            6'h08, 6'h0F, 6'h23: return int'(i[20:16]);
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mkR(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    initial begin
        exp_req = 0; exp_we = 0; exp_en = 0; exp_fault = 0; exp_busy = 0;
        exp_addr = 0; exp_wdata = 0; exp_inst3 = 0; exp_data = 0; exp_waddr = 0;
        m_inst = 0; m_waited = 0;
    end

    always @(posedge clk) begin
        int d;
        exp_fault = 1'b0;
        if (!rst_n) begin
            exp_req = 0; exp_we = 0; exp_en = 0; exp_busy = 0;
            exp_addr = 0; exp_wdata = 0; exp_inst3 = 0; exp_data = 0; exp_waddr = 0;
        end else if (!exp_busy) begin
            d = destOf(inst2);
            exp_en = 1'b0;
            if (inst2[31:26] == 6'h23 || inst2[31:26] == 6'h2B) begin
                if (result % 4 == 0) begin
                    exp_req   = 1'b1;
                    exp_we    = (inst2[31:26] == 6'h2B);
                    exp_addr  = result;
                    exp_wdata = to_mem2;
                    m_inst    = inst2;
                    m_waited  = 0;
                    exp_busy  = 1'b1;
                    exp_inst3 = 0;
                end else begin
                    exp_fault = 1'b1;
                    exp_inst3 = inst2;
                end
            end else begin
                exp_inst3 = inst2;
                if (d > 0) begin
                    exp_en    = 1'b1;
                    exp_data  = result;
                    exp_waddr = 5'(d);
                end
            end
        end else begin
            m_waited++;
            exp_en    = 1'b0;
            exp_inst3 = 0;
            if (dmem_ack) begin
                d = destOf(m_inst);
                exp_req   = 1'b0;
                exp_busy  = 1'b0;
                exp_inst3 = m_inst;
                if (m_inst[31:26] == 6'h23 && d > 0) begin
                    exp_en    = 1'b1;
                    exp_data  = dmem_rdata;
                    exp_waddr = 5'(d);
                end
            end else if (m_waited == TMO) begin
                exp_req   = 1'b0;
                exp_busy  = 1'b0;
                exp_fault = 1'b1;
                exp_inst3 = m_inst;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("dmem_req",   32'(dmem_req),  32'(exp_req));
        checkOutput("dmem_we",    32'(dmem_we),   32'(exp_we));
        checkOutput("dmem_addr",  dmem_addr,      exp_addr);
        checkOutput("dmem_wdata", dmem_wdata,     exp_wdata);
        checkOutput("inst3",      inst3,          exp_inst3);
        checkOutput("wb_data",    wb_data,        exp_data);
        checkOutput("wb_enable",  32'(wb_enable), 32'(exp_en));
        checkOutput("mem_busy",   32'(mem_busy),  32'(exp_busy));
        checkOutput("mem_fault",  32'(mem_fault), 32'(exp_fault));
        if (exp_en) checkOutput("wb_addr", 32'(wb_addr), 32'(exp_waddr));
    end

    task automatic applyStimulus(input logic [31:0] i, input logic [31:0] r,
                                 input logic [31:0] w, input logic a,
                                 input logic [31:0] rd, input logic rn);
        inst2 = i; result = r; to_mem2 = w; dmem_ack = a; dmem_rdata = rd; rst_n = rn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic randomInst(output logic [31:0] i, output logic [31:0] r);
        logic [4:0] a, b, c;
        a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
        case ($urandom_range(0, 11))
            0:  i = mkI(6'h08, a, b, 16'($urandom));
            1:  i = mkI(6'h0F, 5'd0, b, 16'($urandom));
            2:  i = mkR(a, b, c, 6'h20);
            3:  i = mkR(a, b, c, 6'h19);
            4:  i = mkR(a, b, c, 6'h26);
            5:  i = mkR(5'd0, b, c, 6'h00);
            6:  i = mkR(a, b, c, 6'h2A);
            7:  i = mkI(6'h23, a, b, 16'($urandom));
            8:  i = mkI(6'h2B, a, b, 16'($urandom));
            9:  i = mkI(($urandom % 2 == 0) ? 6'h04 : 6'h05, a, b, 16'($urandom));
            10: i = {6'h02, 26'($urandom)};
            default: i = ($urandom % 2 == 0) ? 32'd0 : mkI(6'h0D, a, b, 16'($urandom));
        endcase
        r = $urandom;
        if ($urandom % 4 != 0) r[1:0] = 2'b00;
        else r[1:0] = 2'($urandom_range(1, 3));
    endtask

    localparam logic [31:0] LW8   = 32'h8C880000;
    localparam logic [31:0] ADDI9 = 32'h21290001;
    localparam logic [31:0] SW6   = 32'hAC460004;

    initial begin
        logic [31:0] ri, rr;
        $display("[TB] start");
        inst2 = 0; result = 0; to_mem2 = 0; dmem_ack = 0; dmem_rdata = 0; rst_n = 0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checkOutput("rst_inst3", inst3, 32'h0);
        checkOutput("rst_req", 32'(dmem_req), 32'h0);
        checkOutput("rst_wb_en", 32'(wb_enable), 32'h0);

        applyStimulus(32'h20A50003, 32'd7, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("addi_inst3", inst3, 32'h20A50003);
        checkOutput("addi_waddr", 32'(wb_addr), 32'd5);
        checkOutput("addi_data", wb_data, 32'd7);
        checkOutput("addi_en", 32'(wb_enable), 32'd1);

        applyStimulus(LW8, 32'h100, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("lw_req1", 32'(dmem_req), 32'd1);
        checkOutput("lw_addr", dmem_addr, 32'h100);
        checkOutput("lw_we", 32'(dmem_we), 32'd0);
        checkOutput("lw_busy1", 32'(mem_busy), 32'd1);
        applyStimulus(ADDI9, 32'd5, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("lw_req2", 32'(dmem_req), 32'd1);
        checkOutput("lw_bubble", inst3, 32'h0);
        applyStimulus(ADDI9, 32'd5, 32'd0, 1'b1, 32'hDEADBEEF, 1'b1);
        checkOutput("lw_done_req", 32'(dmem_req), 32'd0);
        checkOutput("lw_done_inst3", inst3, LW8);
        checkOutput("lw_waddr", 32'(wb_addr), 32'd8);
        checkOutput("lw_data", wb_data, 32'hDEADBEEF);
        applyStimulus(ADDI9, 32'd5, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("held_inst3", inst3, ADDI9);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("held_once", inst3, 32'h0);

        applyStimulus(SW6, 32'h204, 32'h12345678, 1'b0, 32'd0, 1'b1);
        checkOutput("sw_we", 32'(dmem_we), 32'd1);
        checkOutput("sw_wdata", dmem_wdata, 32'h12345678);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1);
        checkOutput("sw_inst3", inst3, SW6);
        checkOutput("sw_en", 32'(wb_enable), 32'd0);

        applyStimulus(LW8, 32'h102, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("mis_req", 32'(dmem_req), 32'd0);
        checkOutput("mis_fault", 32'(mem_fault), 32'd1);
        checkOutput("mis_inst3", inst3, LW8);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("mis_pulse", 32'(mem_fault), 32'd0);

        applyStimulus(LW8, 32'h200, 32'd0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < TMO - 1; k++) begin
            applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
            checkOutput("tmo_req_held", 32'(dmem_req), 32'd1);
        end
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("tmo_req", 32'(dmem_req), 32'd0);
        checkOutput("tmo_fault", 32'(mem_fault), 32'd1);
        checkOutput("tmo_busy", 32'(mem_busy), 32'd0);

        applyStimulus(LW8, 32'h300, 32'd0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < TMO - 1; k++)
            applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b1, 32'hCAFEF00D, 1'b1);
        checkOutput("tie_fault", 32'(mem_fault), 32'd0);
        checkOutput("tie_data", wb_data, 32'hCAFEF00D);
        checkOutput("tie_en", 32'(wb_enable), 32'd1);

        applyStimulus(LW8, 32'h400, 32'd0, 1'b0, 32'd0, 1'b1);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        checkOutput("rstacc_req", 32'(dmem_req), 32'd0);
        checkOutput("rstacc_addr", dmem_addr, 32'd0);
        checkOutput("rstacc_busy", 32'(mem_busy), 32'd0);
        applyStimulus(32'd0, 32'd0, 32'd0, 1'b1, 32'h1111, 1'b1);
        checkOutput("late_ack_en", 32'(wb_enable), 32'd0);
        checkOutput("late_ack_data", wb_data, 32'd0);

        applyStimulus(32'd0, 32'h55, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("nop_en", 32'(wb_enable), 32'd0);
        applyStimulus(32'h20A00005, 32'd9, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("r0_en", 32'(wb_enable), 32'd0);
        checkOutput("r0_inst3", inst3, 32'h20A00005);

        for (int n = 0; n < 3000; n++) begin
            randomInst(ri, rr);
            applyStimulus(ri, rr, $urandom,
                          exp_busy ? ($urandom % 3 == 0) : ($urandom % 8 == 0),
                          $urandom, ($urandom % 80 != 0));
        end

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
